// File: rtl/cursor_move_ctrl.sv
// cursor_move_ctrl
// Turns four debounced arrow keys into single-cycle cursor move strobes.
// A fresh press moves once at once. Holding the same key moves again after
// DELAY_CYCLES, and then every RATE_CYCLES. Losing enable mid-hold locks
// the block out until every key has been released.
module cursor_move_ctrl #(
    parameter int DELAY_CYCLES = 25_000_000,
    parameter int RATE_CYCLES  = 5_000_000,
    parameter int CNT_W        = 25
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic key_right,
    input  logic key_left,
    input  logic key_up,
    input  logic key_down,
    output logic move_en,
    output logic move_right,
    output logic move_left,
    output logic move_up,
    output logic move_down,
    output logic repeating
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    // Terminal counts: the strobe fires on the edge where the timer shows these.
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic move_en_q, move_en_d;
    logic move_right_q, move_right_d;
    logic move_left_q, move_left_d;
    logic move_up_q, move_up_d;
    logic move_down_q, move_down_d;
    logic repeating_q, repeating_d;

    logic keys_any_s;
    logic dir_key_s;
    logic strobe_s;
    dir_t winner_s;

    // Fixed-priority key arbitration and lookup of the key that matches dir.
    always_comb begin
        keys_any_s = key_right | key_left | key_up | key_down;
        winner_s   = DIR_DOWN;
        if (key_right) begin
            winner_s = DIR_RIGHT;
        end else if (key_left) begin
            winner_s = DIR_LEFT;
        end else if (key_up) begin
            winner_s = DIR_UP;
        end else begin
            winner_s = DIR_DOWN;
        end
        case (dir_q)
            DIR_RIGHT: dir_key_s = key_right;
            DIR_LEFT:  dir_key_s = key_left;
            DIR_UP:    dir_key_s = key_up;
            DIR_DOWN:  dir_key_s = key_down;
            default:   dir_key_s = 1'b0;
        endcase
    end

    // Next-state, timer and strobe decision. Enable loss beats key release,
    // which beats the timer terminal count.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        strobe_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (enable && keys_any_s) begin
                    dir_d    = winner_s;
                    state_d  = ST_DELAY;
                    strobe_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!enable) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CNT_ZERO;
                end else if (!dir_key_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == ((state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    state_d  = ST_REPEAT;
                    cnt_d    = CNT_ZERO;
                    strobe_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                cnt_d = CNT_ZERO;
                if (!keys_any_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode: one-hot direction only alongside the strobe.
    always_comb begin
        move_en_d    = strobe_s;
        move_right_d = strobe_s && (dir_d == DIR_RIGHT);
        move_left_d  = strobe_s && (dir_d == DIR_LEFT);
        move_up_d    = strobe_s && (dir_d == DIR_UP);
        move_down_d  = strobe_s && (dir_d == DIR_DOWN);
        repeating_d  = (state_d == ST_REPEAT);
    end

    // State, timer, direction and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_RIGHT;
            cnt_q        <= CNT_ZERO;
            move_en_q    <= 1'b0;
            move_right_q <= 1'b0;
            move_left_q  <= 1'b0;
            move_up_q    <= 1'b0;
            move_down_q  <= 1'b0;
            repeating_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            move_en_q    <= move_en_d;
            move_right_q <= move_right_d;
            move_left_q  <= move_left_d;
            move_up_q    <= move_up_d;
            move_down_q  <= move_down_d;
            repeating_q  <= repeating_d;
        end
    end

    assign move_en    = move_en_q;
    assign move_right = move_right_q;
    assign move_left  = move_left_q;
    assign move_up    = move_up_q;
    assign move_down  = move_down_q;
    assign repeating  = repeating_q;

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Bench for cursor_move_ctrl with DELAY_CYCLES=4, RATE_CYCLES=2.
// The reference model tracks how long the current key has been held and
// derives strobes arithmetically from that hold age.
module tb_cursor_move_ctrl;

    localparam int D = 4;
    localparam int R = 2;

    logic clk = 1'b0;
    logic resetn, enable;
    logic key_right, key_left, key_up, key_down;
    logic move_en, move_right, move_left, move_up, move_down, repeating;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // model: phase 0 = idle, 1 = holding, 2 = locked until all keys released
    int m_phase = 0;
    int m_age   = 0;
    int m_dir   = 0;
    logic [5:0] exp_v = 6'b000000;

    cursor_move_ctrl #(
        .DELAY_CYCLES(D),
        .RATE_CYCLES (R),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .key_right (key_right),
        .key_left  (key_left),
        .key_up    (key_up),
        .key_down  (key_down),
        .move_en   (move_en),
        .move_right(move_right),
        .move_left (move_left),
        .move_up   (move_up),
        .move_down (move_down),
        .repeating (repeating)
    );

    always #5 clk = ~clk;

    function automatic logic key_of(int d);
        case (d)
            0:       return key_right;
            1:       return key_left;
            2:       return key_up;
            default: return key_down;
        endcase
    endfunction

    task automatic check(string tag, logic [5:0] expv);
        logic [5:0] obs;
        obs = {move_en, move_right, move_left, move_up, move_down, repeating};
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, expv);
        end
    endtask

    // Advance the model by one edge using the current inputs, clock, compare.
    task automatic tick(string tag);
        logic any;
        logic strobe;
        any    = key_right | key_left | key_up | key_down;
        strobe = 1'b0;
        if (m_phase == 2) begin
            if (!any) m_phase = 0;
        end else if (m_phase == 0) begin
            if (enable && any) begin
                m_dir   = key_right ? 0 : key_left ? 1 : key_up ? 2 : 3;
                m_phase = 1;
                m_age   = 0;
                strobe  = 1'b1;
            end
        end else begin
            if (!enable) begin
                m_phase = 2;
            end else if (!key_of(m_dir)) begin
                m_phase = 0;
            end else begin
                m_age++;
                if (m_age == D || (m_age > D && ((m_age - D) % R) == 0)) strobe = 1'b1;
            end
        end
        exp_v = {strobe, (strobe ? (4'b1000 >> m_dir) : 4'b0000),
                 ((m_phase == 1) && (m_age >= D))};
        @(posedge clk);
        #1;
        check(tag, exp_v);
    endtask

    task automatic set_keys(logic r, logic l, logic u, logic d);
        key_right = r;
        key_left  = l;
        key_up    = u;
        key_down  = d;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_age   = 0;
        m_dir   = 0;
    endtask

    initial begin
        resetn = 1'b0;
        enable = 1'b1;
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", 6'b000000);
        resetn = 1'b1;

        // Idle with no keys
        tick("idle0");
        tick("idle1");

        // Tap: key_up for one edge
        set_keys(1'b0, 1'b0, 1'b1, 1'b0);
        tick("tap_press");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick("tap_after");

        // Hold right through delay and several repeats, then release
        set_keys(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick("hold_right");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick("hold_release");

        // Priority and latching: down+left, then right joins mid-hold
        set_keys(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("prio_left");
        set_keys(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick("latch_left");
        // left released, right and down held: re-press resolves to right
        set_keys(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("handover");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        tick("prio_idle");

        // Disable mid-hold: enable low on edge N+3
        set_keys(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("dis_hold");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick("dis_release");
        enable = 1'b1;
        for (int i = 0; i < 8; i++) tick("dis_locked");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        tick("dis_allup");
        set_keys(1'b0, 1'b0, 1'b0, 1'b1);
        tick("dis_repress");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        tick("dis_idle");

        // Enable low in idle: keys ignored
        enable = 1'b0;
        set_keys(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick("idle_disabled");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        tick("idle_enabled");

        // Collision: release on the terminal-count edge
        set_keys(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick("coll_hold");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        tick("coll_edge");
        tick("coll_idle");

        // Async reset mid-REPEAT, then key still held at release
        set_keys(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick("rst_pre");
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async", 6'b000000);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_held", 6'b000000);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) tick("rst_after");
        set_keys(1'b0, 1'b0, 1'b0, 1'b0);
        tick("rst_idle");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5, 0) == 0) key_right = ~key_right;
            if ($urandom_range(5, 0) == 0) key_left  = ~key_left;
            if ($urandom_range(5, 0) == 0) key_up    = ~key_up;
            if ($urandom_range(5, 0) == 0) key_down  = ~key_down;
            if ($urandom_range(15, 0) == 0) enable   = ~enable;
            if ($urandom_range(40, 0) == 0) begin
                set_keys(1'b0, 1'b0, 1'b0, 1'b0);
                enable = 1'b1;
            end
            if ($urandom_range(3, 0) != 0 && key_of(m_dir) && m_phase == 1) begin
                // bias towards long holds so repeats occur often
                key_right = (m_dir == 0) ? 1'b1 : key_right;
                key_left  = (m_dir == 1) ? 1'b1 : key_left;
                key_up    = (m_dir == 2) ? 1'b1 : key_up;
                key_down  = (m_dir == 3) ? 1'b1 : key_down;
            end
            tick("random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cursor_move_ctrl.md
CURSOR_MOVE_CTRL -- requirements
Module: cursor_move_ctrl

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 25_000_000, meaning hold time before auto-repeat starts (0.5 s at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter RATE_CYCLES, default 5_000_000, meaning auto-repeat period; legal range >= 2.
REQ-003 SHALL have parameter CNT_W, default 25, meaning timer width; must satisfy 2^CNT_W > max(DELAY_CYCLES, RATE_CYCLES).
REQ-004 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1; high means cursor input is accepted (player's turn, no board update in progress).
REQ-007 SHALL have ports key_right, key_left, key_up, key_down, input, 1 each, already synchronized and debounced, active-high.
REQ-008 SHALL have port move_en, output, 1, registered one-cycle move strobe for the cursor position register.
REQ-009 SHALL have ports move_right, move_left, move_up, move_down, output, 1 each, registered one-hot direction, valid only while move_en=1, all 0 otherwise.
REQ-010 SHALL have port repeating, output, 1, registered; high while in state REPEAT.

Function
REQ-011 SHALL implement states IDLE, DELAY, REPEAT, RELEASE plus a CNT_W-bit timer cnt and a latched direction dir.
REQ-012 SHALL arbitrate simultaneous keys by fixed priority right > left > up > down; only the winner is latched into dir.
REQ-013 IDLE: if enable=1 and any key=1 at an edge, SHALL latch the winner into dir, clear cnt, enter DELAY, and assert move_en plus the dir one-hot for the following cycle.
REQ-014 IDLE with enable=0 SHALL remain in IDLE with no strobe, regardless of keys.
REQ-015 DELAY: cnt SHALL increment each cycle; at an edge where cnt==DELAY_CYCLES-1, it SHALL strobe dir, clear cnt, and enter REPEAT.
REQ-016 REPEAT: cnt SHALL increment each cycle; at an edge where cnt==RATE_CYCLES-1, it SHALL strobe dir and clear cnt, remaining in REPEAT.
REQ-017 In DELAY or REPEAT, if the key matching dir reads 0, SHALL enter IDLE with no strobe. A different still-held key SHALL then be handled per REQ-013 at the next edge.
REQ-018 In DELAY or REPEAT, keys other than dir SHALL be ignored; a higher-priority key pressed mid-hold SHALL NOT change dir.
REQ-019 In DELAY, REPEAT or IDLE-exit, if enable=0, SHALL enter RELEASE with no strobe and clear cnt.
REQ-020 RELEASE: SHALL stay until all four keys read 0, then enter IDLE; no strobe is issued in RELEASE even if enable returns.
REQ-021 Priority at one edge SHALL be: enable=0, then dir-key release, then timer terminal count. A suppressed terminal count produces no strobe.
REQ-022 move_en SHALL never be high for two consecutive cycles; at most one direction output SHALL be high at any time.
REQ-023 The timer SHALL never wrap; it is cleared on every state change and on every strobe.

Reset
REQ-024 On resetn=0, the block SHALL asynchronously force state=IDLE, cnt=0, dir=right, and move_en, all direction outputs and repeating to 0.
REQ-025 After resetn deasserts, a key already held SHALL be treated as a new press per REQ-013 if enable=1.

Verification
All scenarios run with DELAY_CYCLES=4 and RATE_CYCLES=2.
REQ-026 Tap: key_up high for 1 cycle at edge N, enable=1 -> move_en and move_up high only in cycle after N; no further strobes.
REQ-027 Hold: key_right held from edge N -> strobes after edges N, N+4, N+6, N+8; repeating=1 from after N+4; release -> IDLE, strobes stop, repeating=0.
REQ-028 Priority and latching: key_down and key_left rise together -> move_left strobe; then key_right pressed while held -> later repeats remain move_left.
REQ-029 Disable mid-hold: enable falls at edge N+3 while key held -> no strobe at N+4; state RELEASE. Enable returns with key still held -> no strobe until all keys released and re-pressed.
REQ-030 Collision: dir key releases at the same edge cnt reaches terminal count -> no strobe, state IDLE.
REQ-031 Reset mid-REPEAT: resetn low asynchronously -> outputs 0 immediately. Deassert with key held and enable=1 -> single first strobe, then the DELAY sequence restarts.
